butterfly_per: RTL and testbench

Memory-mapped radix-2 decimation-in-time butterfly coprocessor. It is a responder on the openMSP430 peripheral bus, and its `per_dout` is OR-ed into the CPU's peripheral read mux. Software writes A, B and twiddle W (complex Q1.15), then sets START. The block computes X=(A+B·W)/2 and Y=(A−B·W)/2 over several cycles using one shared 16×16 multiplier, and flags DONE, optionally raising an interrupt.

---
 rtl/butterfly_per_pkg.sv | 36 +++
 rtl/bfly_sat_shift.sv | 36 +++
 rtl/butterfly_per.sv | 200 ++++++++++++++++++++
 tb/tb_butterfly_per.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/butterfly_per_pkg.sv
// butterfly_per_pkg
//   Shared definitions for the butterfly coprocessor: register word offsets,
//   CTRL bit positions, FSM state encoding and Q1.15 saturation limits.
package butterfly_per_pkg;

  // Register word offsets inside the 16-word window
  localparam logic [3:0] BFLY_CTRL = 4'd0;
  localparam logic [3:0] BFLY_AR   = 4'd1;
  localparam logic [3:0] BFLY_AI   = 4'd2;
  localparam logic [3:0] BFLY_BR   = 4'd3;
  localparam logic [3:0] BFLY_BI   = 4'd4;
  localparam logic [3:0] BFLY_WR   = 4'd5;
  localparam logic [3:0] BFLY_WI   = 4'd6;
  localparam logic [3:0] BFLY_XR   = 4'd7;
  localparam logic [3:0] BFLY_XI   = 4'd8;
  localparam logic [3:0] BFLY_YR   = 4'd9;
  localparam logic [3:0] BFLY_YI   = 4'd10;

  // CTRL bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_BUSY  = 8;
  localparam int CTRL_DONE  = 9;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2
  } bfly_state_e;

  // Q1.15 saturation limits, widened to the 19-bit intermediate width
  localparam logic signed [18:0] Q15_MAX = 19'sd32767;
  localparam logic signed [18:0] Q15_MIN = -19'sd32768;

endpackage

// File: rtl/bfly_sat_shift.sv
// bfly_sat_shift
//   One output lane of the butterfly: y = sat16((a +/- t) >>> 1).
//   Ports:
//     a   in  16  A component (Q1.15), sign-extended internally
//     t   in  18  scaled product term (acc >>> 15, truncated to 18 bits)
//     sub in  1   0: a + t, 1: a - t
//     y   out 16  saturated result
module bfly_sat_shift (
  input  logic signed [15:0] a,
  input  logic signed [17:0] t,
  input  logic               sub,
  output logic        [15:0] y
);
  import butterfly_per_pkg::*;

  logic signed [18:0] a_ext;
  logic signed [18:0] t_ext;
  logic signed [18:0] sum;
  logic signed [18:0] half;

  always_comb begin
    a_ext = {{3{a[15]}}, a};
    t_ext = {t[17], t};
    sum   = sub ? (a_ext - t_ext) : (a_ext + t_ext);
    // Arithmetic shift floors towards minus infinity
    half  = sum >>> 1;
    if (half > Q15_MAX) begin
      y = Q15_MAX[15:0];
    end else if (half < Q15_MIN) begin
      y = Q15_MIN[15:0];
    end else begin
      y = half[15:0];
    end
  end

endmodule

// File: rtl/butterfly_per.sv
// butterfly_per
//   Memory-mapped radix-2 DIT butterfly on the openMSP430 peripheral bus.
//   Computes X = (A + B*W)/2 and Y = (A - B*W)/2 in Q1.15 using a single
//   shared 16x16 multiplier over four cycles.
//   Ports:
//     mclk      in  1   system clock
//     reset_n   in  1   asynchronous active-low reset
//     per_addr  in  14  word address
//     per_din   in  16  write data
//     per_en    in  1   access enable
//     per_we    in  2   byte write enables (00 = read)
//     per_dout  out 16  combinational read data, 0 when not read-selected
//     irq_bfly  out 1   level interrupt IE & DONE
//   Build option: define BUTTERFLY_IRQ_EN to implement the IE bit and the
//   interrupt; otherwise IE reads 0 and irq_bfly is tied low.
module butterfly_per #(
  parameter logic [14:0] BASE_ADDR = 15'h0100
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        irq_bfly
);
  import butterfly_per_pkg::*;

  // Bus decode
  logic       sel;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] offs;
  logic       busy;
  logic       start_req;
  logic       done_clr;
  logic       ie_bit;

  assign sel   = per_en && (per_addr[13:4] == BASE_ADDR[14:5]);
  assign offs  = per_addr[3:0];
  assign wr_en = sel && (per_we != 2'b00);
  assign rd_en = sel && (per_we == 2'b00);

  bfly_state_e        state_reg;
  logic [1:0]         cnt_reg;
  logic signed [32:0] tr_reg;
  logic signed [32:0] ti_reg;
  logic               done_reg;
  logic [3:0][15:0]   res_reg;   // XR, XI, YR, YI
  logic [5:0][15:0]   opnd;      // AR, AI, BR, BI, WR, WI

  assign busy      = (state_reg != IDLE);
  assign start_req = wr_en && (offs == BFLY_CTRL) && per_we[0] &&
                     per_din[CTRL_START] && !busy;
  assign done_clr  = wr_en && (offs == BFLY_CTRL) && per_we[1] &&
                     per_din[CTRL_DONE] && !busy;

  // Operand registers, byte-writable, frozen while a computation runs
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_opnd
      logic [15:0] val_reg;
      always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
          val_reg <= '0;
        end else if (wr_en && !busy && (offs == 4'(gi + 1))) begin
          if (per_we[0]) val_reg[7:0]  <= per_din[7:0];
          if (per_we[1]) val_reg[15:8] <= per_din[15:8];
        end
      end
      assign opnd[gi] = val_reg;
    end
  endgenerate

  // Shared multiplier: cnt selects BR*WR, BI*WI, BR*WI, BI*WR
  logic signed [15:0] mul_a;
  logic signed [15:0] mul_b;
  logic signed [31:0] prod;
  logic signed [32:0] prod_ext;

  always_comb begin
    mul_a = opnd[2];
    mul_b = opnd[4];
    case (cnt_reg)
      2'd0: begin mul_a = opnd[2]; mul_b = opnd[4]; end
      2'd1: begin mul_a = opnd[3]; mul_b = opnd[5]; end
      2'd2: begin mul_a = opnd[2]; mul_b = opnd[5]; end
      default: begin mul_a = opnd[3]; mul_b = opnd[4]; end
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {prod[31], prod};

  // acc >>> 15 truncated to 18 bits is exactly acc[32:15]
  logic signed [17:0] tr_t;
  logic signed [17:0] ti_t;
  assign tr_t = tr_reg[32:15];
  assign ti_t = ti_reg[32:15];

  // Four output lanes: X uses add, Y uses subtract; even lanes are real
  logic [3:0][15:0] sat_out;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      bfly_sat_shift u_sat (
        .a   ((gi % 2) ? opnd[1] : opnd[0]),
        .t   ((gi % 2) ? ti_t : tr_t),
        .sub (gi >= 2),
        .y   (sat_out[gi])
      );
    end
  endgenerate

  // Sequencer
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tr_reg    <= '0;
      ti_reg    <= '0;
      done_reg  <= 1'b0;
      res_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // START takes priority over a DONE-clear in the same write
          if (start_req) begin
            state_reg <= MUL;
            cnt_reg   <= '0;
            tr_reg    <= '0;
            ti_reg    <= '0;
            done_reg  <= 1'b0;
          end else if (done_clr) begin
            done_reg  <= 1'b0;
          end
        end
        MUL: begin
          case (cnt_reg)
            2'd0:    tr_reg <= tr_reg + prod_ext;
            2'd1:    tr_reg <= tr_reg - prod_ext;
            default: ti_reg <= ti_reg + prod_ext;
          endcase
          cnt_reg <= cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_reg <= SUM;
        end
        SUM: begin
          // All four results update together so readers never see a mix
          res_reg   <= sat_out;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef BUTTERFLY_IRQ_EN
  logic ie_reg;
  // IE stays writable while busy
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ie_reg <= 1'b0;
    end else if (wr_en && (offs == BFLY_CTRL) && per_we[0]) begin
      ie_reg <= per_din[CTRL_IE];
    end
  end
  assign ie_bit   = ie_reg;
  assign irq_bfly = ie_reg & done_reg;
`else
  assign ie_bit   = 1'b0;
  assign irq_bfly = 1'b0;
`endif

  // Read mux
  always_comb begin
    per_dout = '0;
    if (rd_en) begin
      case (offs)
        BFLY_CTRL: begin
          per_dout[CTRL_IE]   = ie_bit;
          per_dout[CTRL_BUSY] = busy;
          per_dout[CTRL_DONE] = done_reg;
        end
        BFLY_AR: per_dout = opnd[0];
        BFLY_AI: per_dout = opnd[1];
        BFLY_BR: per_dout = opnd[2];
        BFLY_BI: per_dout = opnd[3];
        BFLY_WR: per_dout = opnd[4];
        BFLY_WI: per_dout = opnd[5];
        BFLY_XR: per_dout = res_reg[0];
        BFLY_XI: per_dout = res_reg[1];
        BFLY_YR: per_dout = res_reg[2];
        BFLY_YI: per_dout = res_reg[3];
        default: per_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_butterfly_per.sv
// tb_butterfly_per
//   Directed bench for butterfly_per: arithmetic vectors, saturation,
//   busy-time write protection, interrupt/DONE handling, decode and reset.
module tb_butterfly_per;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = 2'b00;
  logic [15:0] per_dout;
  logic        irq_bfly;

  int checks = 0;
  int errors = 0;

  localparam logic [13:0] BASE_W = 14'h0080;   // byte 0x0100 as word address
`ifdef BUTTERFLY_IRQ_EN
  localparam logic [15:0] IE_EXP  = 16'h0002;
  localparam logic        IRQ_EXP = 1'b1;
`else
  localparam logic [15:0] IE_EXP  = 16'h0000;
  localparam logic        IRQ_EXP = 1'b0;
`endif

  always #5 mclk = ~mclk;

  butterfly_per dut (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .irq_bfly (irq_bfly)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    $display("check %-12s observed %h expected %h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [15:0] d, input logic [1:0] we);
    @(negedge mclk);
    per_addr = BASE_W + {10'd0, off};
    per_din  = d;
    per_we   = we;
    per_en   = 1'b1;
    @(posedge mclk);
    #1;
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] off, input logic [15:0] exp);
    logic [15:0] d;
    @(negedge mclk);
    per_addr = BASE_W + {10'd0, off};
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1;
    d = per_dout;
    per_en = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic load(input logic [15:0] ar, input logic [15:0] ai, input logic [15:0] br,
                      input logic [15:0] bi, input logic [15:0] wr, input logic [15:0] wi);
    bus_write(4'd1, ar, 2'b11);
    bus_write(4'd2, ai, 2'b11);
    bus_write(4'd3, br, 2'b11);
    bus_write(4'd4, bi, 2'b11);
    bus_write(4'd5, wr, 2'b11);
    bus_write(4'd6, wi, 2'b11);
  endtask

  initial begin
    // Reset state
    #2;
    per_addr = BASE_W;
    per_en   = 1'b1;
    #1;
    check("rst_ctrl", per_dout, 16'h0000);
    check("rst_irq", {15'd0, irq_bfly}, 16'h0000);
    per_en = 1'b0;
    @(negedge mclk);
    reset_n = 1'b1;
    check_reg("rst_xr", 4'd7, 16'h0000);

    // Vector 1: real-only, with latency checks
    load(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000);
    check_reg("rd_ar", 4'd1, 16'h4000);
    check_reg("rd_wr", 4'd5, 16'h7FFF);
    bus_write(4'd0, 16'h0001, 2'b01);            // E0
    check_reg("v1_busy", 4'd0, 16'h0100);
    repeat (4) @(posedge mclk);                  // E1..E4
    check_reg("v1_pre_e5", 4'd0, 16'h0100);
    @(posedge mclk);                             // E5
    check_reg("v1_done", 4'd0, 16'h0200);
    check_reg("v1_xr", 4'd7, 16'h2FFF);
    check_reg("v1_xi", 4'd8, 16'h0000);
    check_reg("v1_yr", 4'd9, 16'h1000);
    check_reg("v1_yi", 4'd10, 16'h0000);
    check("v1_irq", {15'd0, irq_bfly}, 16'h0000);

    // Vector 2: multiply by -j
    load(16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h8000);
    bus_write(4'd0, 16'h0001, 2'b01);
    repeat (5) @(posedge mclk);
    check_reg("v2_xr", 4'd7, 16'h0000);
    check_reg("v2_xi", 4'd8, 16'hF000);
    check_reg("v2_yr", 4'd9, 16'h0000);
    check_reg("v2_yi", 4'd10, 16'h1000);

    // Vector 3: saturation on XI
    load(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    bus_write(4'd0, 16'h0001, 2'b01);
    repeat (5) @(posedge mclk);
    check_reg("v3_xr", 4'd7, 16'h3FFF);
    check_reg("v3_xi", 4'd8, 16'h7FFF);
    check_reg("v3_yr", 4'd9, 16'h3FFF);
    check_reg("v3_yi", 4'd10, 16'hBFFF);

    // Byte lanes
    bus_write(4'd1, 16'h1234, 2'b01);
    check_reg("byte_lo", 4'd1, 16'h7F34);
    bus_write(4'd1, 16'hAB00, 2'b10);
    check_reg("byte_hi", 4'd1, 16'hAB34);

    // Writes during BUSY are ignored; X/Y hold old result until E5
    load(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000);
    bus_write(4'd0, 16'h0001, 2'b01);            // E0
    bus_write(4'd1, 16'h1234, 2'b11);            // E1
    bus_write(4'd0, 16'h0001, 2'b01);            // E2
    check_reg("busy_oldxr", 4'd7, 16'h3FFF);
    repeat (2) @(posedge mclk);                  // E3, E4
    check_reg("busy_pre", 4'd0, 16'h0100);
    @(posedge mclk);                             // E5
    check_reg("busy_done", 4'd0, 16'h0200);
    check_reg("busy_ar", 4'd1, 16'h4000);
    check_reg("busy_xr", 4'd7, 16'h2FFF);
    repeat (3) @(posedge mclk);
    check_reg("busy_single", 4'd0, 16'h0200);

    // Decode: read mux silent on writes, unselected and unmapped accesses
    @(negedge mclk);
    per_addr = BASE_W;
    per_din  = 16'h0000;
    per_we   = 2'b10;
    per_en   = 1'b1;
    #1;
    check("wr_dout", per_dout, 16'h0000);
    @(posedge mclk);
    #1;
    per_en = 1'b0;
    per_we = 2'b00;
    @(negedge mclk);
    per_addr = BASE_W;
    #1;
    check("unsel_en", per_dout, 16'h0000);
    per_addr = 14'h0090;
    per_en   = 1'b1;
    #1;
    check("other_base", per_dout, 16'h0000);
    per_en = 1'b0;
    bus_write(4'd12, 16'hFFFF, 2'b11);
    check_reg("unmapped12", 4'd12, 16'h0000);

    // START and DONE-clear together: START wins
    bus_write(4'd0, 16'h0201, 2'b11);
    check_reg("start_wins", 4'd0, 16'h0100);
    repeat (5) @(posedge mclk);
    check_reg("sw_done", 4'd0, 16'h0200);

    // DONE clear and interrupt
    bus_write(4'd0, 16'h0200, 2'b10);
    check_reg("done_clr", 4'd0, 16'h0000);
    bus_write(4'd0, 16'h0002, 2'b01);
    check_reg("ie_read", 4'd0, IE_EXP);
    bus_write(4'd0, 16'h0003, 2'b01);            // E0
    repeat (4) @(posedge mclk);                  // E1..E4
    @(negedge mclk);
    check("irq_pre", {15'd0, irq_bfly}, 16'h0000);
    @(posedge mclk);                             // E5
    @(negedge mclk);
    check("irq_rise", {15'd0, irq_bfly}, {15'd0, IRQ_EXP});
    check_reg("irq_ctrl", 4'd0, 16'h0200 | IE_EXP);
    bus_write(4'd0, 16'h0200, 2'b10);
    @(negedge mclk);
    check("irq_clr", {15'd0, irq_bfly}, 16'h0000);
    check_reg("irq_clr_ctl", 4'd0, IE_EXP);

    // Reset in the middle of an operation
    bus_write(4'd0, 16'h0001, 2'b01);            // E0
    @(posedge mclk);                             // E1
    @(posedge mclk);                             // E2
    #1;
    reset_n = 1'b0;
    #1;
    per_addr = BASE_W;
    per_en   = 1'b1;
    #1;
    check("mrst_ctrl", per_dout, 16'h0000);
    per_addr = BASE_W + 14'd7;
    #1;
    check("mrst_xr", per_dout, 16'h0000);
    per_addr = BASE_W + 14'd1;
    #1;
    check("mrst_ar", per_dout, 16'h0000);
    check("mrst_irq", {15'd0, irq_bfly}, 16'h0000);
    per_en = 1'b0;
    @(negedge mclk);
    reset_n = 1'b1;
    load(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000);
    bus_write(4'd0, 16'h0001, 2'b01);
    repeat (5) @(posedge mclk);
    check_reg("post_done", 4'd0, 16'h0200);
    check_reg("post_xr", 4'd7, 16'h2FFF);
    check_reg("post_yr", 4'd9, 16'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
